// File: rtl/cpu2_seq_pkg.sv
// rtl/cpu2_seq_pkg.sv - CPU-2 sequencer encodings, field positions and ALU op constants
// Optional STEP state exists only when CPU2_SINGLE_STEP_EN is defined.
package cpu2_seq_pkg;

    typedef enum logic [1:0] {
        OPC_ALU    = 2'b00,
        OPC_BRANCH = 2'b01,
        OPC_LOADI  = 2'b10,
        OPC_HALT   = 2'b11
    } opclass_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3
`ifdef CPU2_SINGLE_STEP_EN
        ,
        ST_STEP  = 3'd4
`endif
    } state_e;

    localparam int CW_ASEL_LSB = 11;
    localparam int CW_BSEL_LSB = 8;
    localparam int CW_DEST_LSB = 5;
    localparam int CW_OP_LSB   = 0;
    localparam int SEL_W       = 3;

    localparam int INSTR_COND_BIT = 13;
    localparam int LOADI_DEST_LSB = 5;

    localparam logic [4:0] ALU_PASS = 5'b00000;
    localparam logic [4:0] ALU_INC  = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00101;

endpackage

// File: rtl/cpu2_decode.sv
// rtl/cpu2_decode.sv - combinational instruction decode: IR to class, control word, imm, target, cond
module cpu2_decode
    import cpu2_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CTRLWORD = 14,
    parameter int ADDR_W   = 8
) (
    input  logic [15:0]         ir,
    output opclass_e            opclass,
    output logic [CTRLWORD-1:0] ctrl,
    output logic [WIDTH-1:0]    imm,
    output logic [ADDR_W-1:0]   target,
    output logic                cond
);

    assign opclass = opclass_e'(ir[15:14]);
    assign imm     = ir[WIDTH-1:0];
    assign target  = ir[ADDR_W-1:0];
    assign cond    = ir[INSTR_COND_BIT];

    // LOADI selects A=in, op=PASS, so the immediate flows straight into dest.
    always_comb begin
        ctrl = '0;
        case (opclass)
            OPC_ALU:   ctrl = ir[CTRLWORD-1:0];
            OPC_LOADI: ctrl[CW_DEST_LSB +: SEL_W] = ir[LOADI_DEST_LSB +: SEL_W];
            default:   ctrl = '0;
        endcase
    end

endmodule

// File: rtl/cpu2_sequencer.sv
// rtl/cpu2_sequencer.sv - CPU-2 fetch/decode/execute sequencer driving the register_and_alu datapath
// CPU2_SINGLE_STEP_EN adds the step port and a STEP state after every non-HALT EXEC.
module cpu2_sequencer
    import cpu2_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CTRLWORD = 14,
    parameter int ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_data,
    input  logic [WIDTH-1:0]    dp_out,
    output logic [CTRLWORD-1:0] ctrl_word,
    output logic [WIDTH-1:0]    imm_out,
    output logic                zero_flag,
    output logic                busy,
    output logic                halted
`ifdef CPU2_SINGLE_STEP_EN
    ,
    input  logic                step
`endif
);

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [15:0]         ir;
    logic [WIDTH-1:0]    imm_q;
    logic                zero_q;

    opclass_e            dec_class;
    logic [CTRLWORD-1:0] dec_ctrl;
    logic [WIDTH-1:0]    dec_imm;
    logic [ADDR_W-1:0]   dec_target;
    logic                dec_cond;
    logic                exec_loadi;
    logic                branch_taken;

    cpu2_decode #(
        .WIDTH    (WIDTH),
        .CTRLWORD (CTRLWORD),
        .ADDR_W   (ADDR_W)
    ) u_decode (
        .ir      (ir),
        .opclass (dec_class),
        .ctrl    (dec_ctrl),
        .imm     (dec_imm),
        .target  (dec_target),
        .cond    (dec_cond)
    );

    assign exec_loadi   = (state == ST_EXEC) && (dec_class == OPC_LOADI);
    assign branch_taken = dec_cond ? zero_q : 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALT: if (start) state_nxt = ST_FETCH;
            ST_FETCH:         if (imem_ack) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (dec_class == OPC_HALT)
                    state_nxt = ST_HALT;
                else
`ifdef CPU2_SINGLE_STEP_EN
                    state_nxt = ST_STEP;
            end
            ST_STEP:          if (step) state_nxt = ST_FETCH;
`else
                    state_nxt = ST_FETCH;
            end
`endif
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Outputs depend on registered state/IR only; the decoder zeroes BRANCH/HALT words.
    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign ctrl_word = (state == ST_EXEC) ? dec_ctrl : '0;
    assign imm_out   = exec_loadi ? dec_imm : imm_q;
    assign zero_flag = zero_q;
    assign halted    = (state == ST_HALT);
`ifdef CPU2_SINGLE_STEP_EN
    assign busy      = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_STEP);
`else
    assign busy      = (state == ST_FETCH) || (state == ST_EXEC);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= '0;
            ir     <= '0;
            imm_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (start) pc <= '0;
                ST_HALT: if (start) begin
                    pc     <= '0;
                    zero_q <= 1'b0;
                end
                ST_FETCH: if (imem_ack) ir <= imem_data;
                ST_EXEC: begin
                    case (dec_class)
                        OPC_ALU, OPC_LOADI: begin
                            zero_q <= (dp_out == '0);
                            pc     <= pc + 1'b1;
                        end
                        OPC_BRANCH: pc <= branch_taken ? dec_target : pc + 1'b1;
                        default:    pc <= pc;
                    endcase
                    if (exec_loadi) imm_q <= dec_imm;
                end
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu2_sequencer.sv
// tb/tb_cpu2_sequencer.sv - directed self-checking bench for cpu2_sequencer with a datapath and memory model
module tb_cpu2_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [3:0]  dp_out;
    logic [13:0] ctrl_word;
    logic [3:0]  imm_out;
    logic        zero_flag, busy, halted;
`ifdef CPU2_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif

    logic [15:0] mem [256];
    logic [3:0]  rf [8];
    logic        rf_clr = 1'b0;
    logic [3:0]  a_val, b_val;
    int          wait_n = 0;
    int          wait_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    cpu2_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .dp_out    (dp_out),
        .ctrl_word (ctrl_word),
        .imm_out   (imm_out),
        .zero_flag (zero_flag),
        .busy      (busy),
        .halted    (halted)
`ifdef CPU2_SINGLE_STEP_EN
        ,
        .step      (step)
`endif
    );

    // Instruction memory: ack after wait_n wait cycles of a held request.
    assign imem_data = mem[imem_addr];
    assign imem_ack  = imem_req && (wait_cnt == wait_n);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else        wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    end

    // register_and_alu model: select 0 reads `in`, dest 0 means no write.
    always_comb begin
        a_val = (ctrl_word[13:11] == 3'd0) ? imm_out : rf[ctrl_word[13:11]];
        b_val = (ctrl_word[10:8] == 3'd0) ? imm_out : rf[ctrl_word[10:8]];
        case (ctrl_word[4:0])
            5'd1:    dp_out = a_val + 4'd1;
            5'd2:    dp_out = a_val + b_val;
            5'd5:    dp_out = a_val - b_val;
            default: dp_out = a_val;
        endcase
    end

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 4'd0;
        end else if (ctrl_word[7:5] != 3'd0) begin
            rf[ctrl_word[7:5]] <= dp_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_rf();
        rf_clr = 1'b1;
        tick();
        rf_clr = 1'b0;
    endtask

    task automatic load_add_prog();
        mem[0] = 16'h8025;   // LOADI R1,5
        mem[1] = 16'h8043;   // LOADI R2,3
        mem[2] = 16'h0A62;   // R3 = R1 + R2
        mem[3] = 16'hC000;   // HALT
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
        rf_clr = 1'b1;
        tick(2);
        rf_clr = 1'b0;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_ctrl", ctrl_word, 0);
        check("rst_imm", imm_out, 0);
        check("rst_zf", zero_flag, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        rst_n = 1'b1;
        tick();

        // Zero-wait add program: 8 cycles from start to HALT.
        load_add_prog();
        wait_n = 0;
        pulse_start();
        check("zw_busy", busy, 1);
        tick();
        check("zw_loadi_ctrl", ctrl_word, 14'h0020);
        check("zw_loadi_imm", imm_out, 5);
        tick(4);
        check("zw_add_ctrl", ctrl_word, 14'h0A62);
        check("zw_add_dp", dp_out, 8);
        tick(2);
        check("zw_halt_exec_ctrl", ctrl_word, 0);
        check("zw_halted_7", halted, 0);
        tick();
        check("zw_halted_8", halted, 1);
        check("zw_r3", rf[3], 8);
        check("zw_zf", zero_flag, 0);
        check("zw_imm_hold", imm_out, 3);

        // Three wait cycles per fetch: request and address held, 5 cycles per instruction.
        clear_rf();
        wait_n = 3;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 4; w++) begin
                check("ws_req", imem_req, 1);
                check("ws_addr", imem_addr, i);
                tick();
            end
            check("ws_exec_busy", busy, 1);
            tick();
        end
        check("ws_halted", halted, 1);
        check("ws_r3", rf[3], 8);
        check("ws_zf", zero_flag, 0);

        // Conditional branch taken on zero flag.
        wait_n = 0;
        mem[0] = 16'h8020;   // LOADI R1,0
        mem[1] = 16'h6020;   // BRANCH.cond 0x20
        mem[2] = 16'hC000;
        mem[8'h20] = 16'hC000;
        pulse_start();
        tick(3);
        check("br_zf_set", zero_flag, 1);
        check("br_exec_ctrl", ctrl_word, 0);
        tick();
        check("br_taken_addr", imem_addr, 8'h20);
        tick(2);
        check("br_taken_halt", halted, 1);

        // Same branch, flag clear: falls through to PC+1.
        mem[0] = 16'h8021;   // LOADI R1,1
        pulse_start();
        tick(3);
        check("br_zf_clr", zero_flag, 0);
        tick();
        check("br_nt_addr", imem_addr, 8'h02);
        tick(2);
        check("br_nt_halt", halted, 1);

        // Unconditional branch with junk above the target bits, then PC wrap.
        mem[0]     = 16'h5FFF;
        mem[8'hFF] = 16'h8027;   // LOADI R1,7
        pulse_start();
        tick(2);
        check("wrap_target", imem_addr, 8'hFF);
        tick();
        check("wrap_loadi_imm", imm_out, 7);
        tick();
        check("wrap_addr", imem_addr, 8'h00);

        // Asynchronous reset in the middle of a stalled fetch.
        load_add_prog();
        wait_n = 3;
        check("mid_req_before", imem_req, 1);
        rst_n = 1'b0;
        #1;
        check("mid_req", imem_req, 0);
        check("mid_addr", imem_addr, 0);
        check("mid_ctrl", ctrl_word, 0);
        check("mid_imm", imm_out, 0);
        check("mid_busy", busy, 0);
        check("mid_halted", halted, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle_req", imem_req, 0);
        pulse_start();
        check("refetch_req", imem_req, 1);
        check("refetch_addr", imem_addr, 0);

`ifdef CPU2_SINGLE_STEP_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_n = 0;
        step = 1'b0;
        tick();
        pulse_start();
        tick(2);
        check("st_park_busy", busy, 1);
        check("st_park_ctrl", ctrl_word, 0);
        check("st_park_req", imem_req, 0);
        check("st_park_pc", imem_addr, 1);
        tick(3);
        check("st_park_hold", imem_req, 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("st_go_req", imem_req, 1);
        check("st_go_addr", imem_addr, 1);
        tick(2);
        check("st_one_only_req", imem_req, 0);
        check("st_one_only_pc", imem_addr, 2);
        tick(2);
        check("st_still_parked", imem_req, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
